// File: rtl/elbeth_fetch_pkg.sv
// Shared constants and types for the elbeth instruction-fetch stage.
package elbeth_fetch_pkg;

    // Exception cause code attached to a fetch from a misaligned PC
    localparam logic [3:0]  ECODE_INST_ADDR_MISALIGNED = 4'd0;

    // addi x0, x0, 0 -- the canonical bubble word
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    // FETCH may issue, KILL drains a request whose data must be dropped,
    // EXC parks on a misaligned PC until redirected
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StKill  = 2'd1,
        StExc   = 2'd2
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/elbeth_fetch_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface elbeth_fetch_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/elbeth_if_skid.sv
// One-entry skid buffer holding a fetched {pc, inst} while IF/ID is stalled.
module elbeth_if_skid (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clear_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        full_o
);

    logic        full_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    // Clear wins over push; push and pop never coincide (stall vs. no stall)
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            full_q <= 1'b0;
        end else if (push_i) begin
            full_q <= 1'b1;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    // Payload only moves on push; contents are meaningless while empty
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q   <= 32'd0;
            inst_q <= 32'd0;
        end else if (push_i && !clear_i) begin
            pc_q   <= push_pc_i;
            inst_q <= push_inst_i;
        end
    end

    assign pc_o   = pc_q;
    assign inst_o = inst_q;
    assign full_o = full_q;

endmodule

// File: rtl/elbeth_fetch.sv
// Instruction fetch stage plus IF/ID pipeline register feeding elbeth_decoder.
module elbeth_fetch
    import elbeth_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_ENCODING
) (
    input  logic                  clk,
    input  logic                  rst,
    elbeth_fetch_if.master        imem,
    input  logic                  if_stall,
    input  logic                  if_flush,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [31:0]           id_pc,
    output logic                  id_valid,
    output logic [6:0]            id_opcode,
    output logic [4:0]            id_inst_0,
    output logic [2:0]            id_inst_1,
    output logic [4:0]            id_inst_2,
    output logic [4:0]            id_inst_3,
    output logic [6:0]            id_inst_4,
    output logic                  id_except,
    output logic [3:0]            id_except_src
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        inflight_q, inflight_d;

    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        id_except_q, id_except_d;

    logic        req;
    logic [31:0] addr_out;
    logic        pc_misaligned;
    logic        ack_fire;
    logic        fetch_accept;
    logic        take_word;
    logic        exc_take;

    logic        skid_push;
    logic        skid_pop;
    logic        skid_clear;
    logic        skid_full;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    assign pc_misaligned = is_misaligned(pc_q);

    // While a request is outstanding the address is frozen, even if pc moves
    assign addr_out = inflight_q ? addr_q : pc_q;

    assign ack_fire     = req && imem.imem_ack;
    // pc advances on any FETCH ack not overridden by redirect
    assign fetch_accept = (state_q == StFetch) && ack_fire && !redirect_valid;
    // a flush drops the word arriving in the same cycle
    assign take_word    = fetch_accept && !if_flush;
    assign exc_take     = (state_q == StFetch) && pc_misaligned && !inflight_q && !skid_full &&
                          !if_stall && !if_flush && !redirect_valid;

    assign skid_push  = take_word && if_stall;
    assign skid_pop   = skid_full && !if_stall && !if_flush && !redirect_valid;
    assign skid_clear = redirect_valid || if_flush;

    elbeth_if_skid u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (skid_push),
        .pop_i       (skid_pop),
        .clear_i     (skid_clear),
        .push_pc_i   (addr_out),
        .push_inst_i (imem.imem_rdata),
        .pc_o        (skid_pc),
        .inst_o      (skid_inst),
        .full_o      (skid_full)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; redirect beats everything else
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (redirect_valid) begin
                    state_d = (req && !imem.imem_ack) ? StKill : StFetch;
                end else if (exc_take) begin
                    state_d = StExc;
                end
            end
            StKill: begin
                if (imem.imem_ack) begin
                    state_d = StFetch;
                end
            end
            StExc: begin
                if (redirect_valid) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // FSM outputs: request enable per state, forced low during reset
    always_comb begin
        req = 1'b0;
        unique case (state_q)
            StFetch: req = inflight_q || (!skid_full && !pc_misaligned);
            StKill:  req = 1'b1;
            default: req = 1'b0;
        endcase
        if (rst) begin
            req = 1'b0;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr_out;

    // Next PC, outstanding-request tracking and IF/ID contents
    always_comb begin
        pc_d        = pc_q;
        addr_d      = addr_q;
        inflight_d  = req && !imem.imem_ack;
        id_inst_d   = id_inst_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        id_except_d = id_except_q;

        if (req && !inflight_q) begin
            addr_d = addr_out;
        end

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fetch_accept) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect_valid || if_flush) begin
            id_inst_d   = NOP_INST;
            id_pc_d     = 32'd0;
            id_valid_d  = 1'b0;
            id_except_d = 1'b0;
        end else if (if_stall) begin
            // hold IF/ID
        end else if (skid_full) begin
            id_inst_d   = skid_inst;
            id_pc_d     = skid_pc;
            id_valid_d  = 1'b1;
            id_except_d = 1'b0;
        end else if (take_word) begin
            id_inst_d   = imem.imem_rdata;
            id_pc_d     = addr_out;
            id_valid_d  = 1'b1;
            id_except_d = 1'b0;
        end else if (exc_take) begin
            id_inst_d   = NOP_INST;
            id_pc_d     = pc_q;
            id_valid_d  = 1'b1;
            id_except_d = 1'b1;
        end else begin
            id_inst_d   = NOP_INST;
            id_pc_d     = 32'd0;
            id_valid_d  = 1'b0;
            id_except_d = 1'b0;
        end
    end

    // Datapath and IF/ID registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            inflight_q  <= 1'b0;
            id_inst_q   <= NOP_INST;
            id_pc_q     <= 32'd0;
            id_valid_q  <= 1'b0;
            id_except_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            id_inst_q   <= id_inst_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            id_except_q <= id_except_d;
        end
    end

    assign id_pc         = id_pc_q;
    assign id_valid      = id_valid_q;
    assign id_opcode     = id_inst_q[6:0];
    assign id_inst_0     = id_inst_q[11:7];
    assign id_inst_1     = id_inst_q[14:12];
    assign id_inst_2     = id_inst_q[19:15];
    assign id_inst_3     = id_inst_q[24:20];
    assign id_inst_4     = id_inst_q[31:25];
    assign id_except     = id_except_q;
    assign id_except_src = id_except_q ? ECODE_INST_ADDR_MISALIGNED : 4'd0;

endmodule
